mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the 5-stage RISC-V pipeline.
// Takes one EX/MEM entry per handshake and runs the load or store over a
// req/ack data-memory port. Memory latency is variable. Sub-word store data
// is replicated across lanes with matching byte enables. Loads are extracted
// and sign- or zero-extended. The stage returns one registered result per
// entry and holds off the EX/MEM register while a bus access is outstanding.
module mem_access_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mem_read,
  input  logic                   in_mem_write,
  input  logic [2:0]             in_funct3,
  input  logic [31:0]            in_addr,
  input  logic [31:0]            in_wr_data,
  input  logic [4:0]             in_rd,
  input  logic                   in_reg_write,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_be,
  input  logic                   dmem_ack,
  input  logic [31:0]            dmem_rdata,
  output logic                   out_valid,
  output logic [4:0]             out_rd,
  output logic                   out_reg_write,
  output logic [31:0]            out_data,
  output logic                   misalign_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_reg;

  // Fields kept for the access in flight, needed to format the result on ack.
  logic [2:0]  lat_funct3_reg;
  logic [1:0]  lat_lane_reg;
  logic [31:0] lat_addr_reg;
  logic [4:0]  lat_rd_reg;
  logic        lat_reg_write_reg;
  logic        lat_is_load_reg;

  // Decode of the incoming entry.
  logic        accept;
  logic        is_mem;
  logic        funct3_legal;
  logic        misaligned;
  logic        access_bad;

  // Store lane formatting of the incoming entry.
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Load extraction from the returned word.
  logic [7:0]  rd_bytes [4];
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  // The stage is ready only when no bus transaction is in progress.
  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid & ~flush & in_ready;
  assign is_mem   = in_mem_read | in_mem_write;

  // Classify the size code and alignment of the incoming memory operation.
  always_comb begin
    funct3_legal = 1'b0;
    misaligned   = 1'b0;
    case (in_funct3)
      F3_B:         funct3_legal = 1'b1;
      F3_H:         funct3_legal = 1'b1;
      F3_W:         funct3_legal = 1'b1;
      F3_BU, F3_HU: funct3_legal = ~in_mem_write;
      default:      funct3_legal = 1'b0;
    endcase
    case (in_funct3[1:0])
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = (in_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    access_bad = ~funct3_legal | misaligned;
  end

  // Build the per-lane store enables and data, and split the read word into bytes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);

      assign st_be[gi] = (in_funct3[1:0] == 2'b00) ? (in_addr[1:0] == LANE) :
                         (in_funct3[1:0] == 2'b01) ? (in_addr[1] == LANE[1]) :
                                                     1'b1;

      assign st_wdata[8*gi +: 8] =
          (in_funct3[1:0] == 2'b00) ? in_wr_data[7:0] :
          (in_funct3[1:0] == 2'b01) ? (LANE[0] ? in_wr_data[15:8] : in_wr_data[7:0]) :
                                      in_wr_data[8*gi +: 8];

      assign rd_bytes[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  // Select and extend the loaded byte or halfword using the latched lane.
  always_comb begin
    rd_byte   = rd_bytes[lat_lane_reg];
    rd_half   = lat_lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (lat_funct3_reg)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_BU:   load_data = {24'b0, rd_byte};
      F3_HU:   load_data = {16'b0, rd_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Count the cycles in which the stage holds off EX/MEM. The count stops at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (!in_ready && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

  // Main controller: accept, issue the bus access, wait for ack, and register the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      dmem_be           <= '0;
      out_valid         <= 1'b0;
      out_rd            <= '0;
      out_reg_write     <= 1'b0;
      out_data          <= '0;
      misalign_err      <= 1'b0;
      lat_funct3_reg    <= '0;
      lat_lane_reg      <= '0;
      lat_addr_reg      <= '0;
      lat_rd_reg        <= '0;
      lat_reg_write_reg <= 1'b0;
      lat_is_load_reg   <= 1'b0;
    end else begin
      // out_valid and misalign_err are single-cycle pulses.
      out_valid    <= 1'b0;
      misalign_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              out_valid     <= 1'b1;
              out_rd        <= in_rd;
              out_reg_write <= in_reg_write;
              out_data      <= in_addr;
            end else if (access_bad) begin
              // The access is misaligned or illegal. Report it without touching memory.
              out_valid     <= 1'b1;
              misalign_err  <= 1'b1;
              out_rd        <= in_rd;
              out_reg_write <= 1'b0;
              out_data      <= in_addr;
            end else begin
              lat_funct3_reg    <= in_funct3;
              lat_lane_reg      <= in_addr[1:0];
              lat_addr_reg      <= in_addr;
              lat_rd_reg        <= in_rd;
              lat_reg_write_reg <= in_reg_write;
              lat_is_load_reg   <= in_mem_read;
              dmem_req          <= 1'b1;
              dmem_we           <= in_mem_write;
              dmem_addr         <= {in_addr[31:2], 2'b00};
              dmem_wdata        <= in_mem_write ? st_wdata : 32'h0;
              dmem_be           <= in_mem_write ? st_be : 4'hF;
              state_reg         <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            state_reg <= IDLE;
            // A flush on the ack cycle cancels the result due next cycle.
            if (!flush) begin
              out_valid     <= 1'b1;
              out_rd        <= lat_rd_reg;
              out_reg_write <= lat_is_load_reg & lat_reg_write_reg;
              out_data      <= lat_is_load_reg ? load_data : lat_addr_reg;
            end
          end else if (flush) begin
            // The bus access cannot be abandoned. Drain it and drop the data.
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage.
// Inputs are driven 1 time unit after each rising edge.
// Registered outputs are sampled at the same point.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wr_data;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [31:0] out_data;
  logic        misalign_err;
  logic [15:0] stall_cycles;

  int checks;
  int errors;

  mem_access_stage #(.STALL_CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_read  (in_mem_read),
    .in_mem_write (in_mem_write),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_wr_data   (in_wr_data),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .out_valid    (out_valid),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .out_data     (out_data),
    .misalign_err (misalign_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_funct3    = 3'b000;
    in_addr      = 32'h0;
    in_wr_data   = 32'h0;
    in_rd        = 5'd0;
    in_reg_write = 1'b0;
    flush        = 1'b0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic rw);
    in_valid     = 1'b1;
    in_mem_read  = rd_en;
    in_mem_write = wr_en;
    in_funct3    = f3;
    in_addr      = addr;
    in_wr_data   = wdata;
    in_rd        = rd;
    in_reg_write = rw;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'h0 || dmem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_dmem got req=%b we=%b be=%h addr=%h want 0", dmem_req, dmem_we, dmem_be, dmem_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || misalign_err !== 1'b0 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_out got valid=%b data=%h err=%b stall=%0d want 0", out_valid, out_data, misalign_err, stall_cycles);
    end
    $display("reset: in_ready=%b out_valid=%b stall=%0d", in_ready, out_valid, stall_cycles);
  endtask

  task automatic test_alu();
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_1234 || out_rd !== 5'd5 || out_reg_write !== 1'b1) begin
      errors++; $display("FAIL alu_result got v=%b data=%h rd=%0d rw=%b want 1/00001234/5/1", out_valid, out_data, out_rd, out_reg_write);
    end
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req got=%b want=0", dmem_req); end
    $display("alu: addr=00001234 -> out_valid=%b out_data=%h rd=%0d", out_valid, out_data, out_rd);
    step();
    checks++;
    if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL alu_pulse got v=%b req=%b want 0/0", out_valid, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0011, 32'h0, 5'd1, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0011 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got v=%b data=%h rdy=%b want 1/00000011/1", out_valid, out_data, in_ready);
    end
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0022, 32'h0, 5'd2, 1'b0);
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0022 || out_rd !== 5'd2 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL b2b_second got v=%b data=%h rd=%0d rw=%b want 1/00000022/2/0", out_valid, out_data, out_rd, out_reg_write);
    end
    $display("back_to_back: second out_data=%h", out_data);
    step();
  endtask

  task automatic test_load_byte();
    do_reset();
    // LB from 0x103 with the ack arriving three cycles after the request rises.
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    step();
    idle_inputs();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h0000_0100 || dmem_be !== 4'hF || in_ready !== 1'b0) begin
      errors++; $display("FAIL lb_req got req=%b we=%b addr=%h be=%h rdy=%b want 1/0/00000100/f/0", dmem_req, dmem_we, dmem_addr, dmem_be, in_ready);
    end
    step();
    checks++;
    if (dmem_req !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lb_hold got req=%b v=%b want 1/0", dmem_req, out_valid);
    end
    step();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80FF_0000;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FF80 || out_rd !== 5'd7 || out_reg_write !== 1'b1) begin
      errors++; $display("FAIL lb_result got v=%b data=%h rd=%0d rw=%b want 1/ffffff80/7/1", out_valid, out_data, out_rd, out_reg_write);
    end
    checks++;
    if (stall_cycles !== 16'd3 || in_ready !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL lb_stall got stall=%0d rdy=%b req=%b want 3/1/0", stall_cycles, in_ready, dmem_req);
    end
    $display("lb: addr=00000103 rdata=80ff0000 -> out_data=%h stall=%0d", out_data, stall_cycles);

    // LBU from the same address and with the same timing.
    drive_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd8, 1'b1);
    step();
    idle_inputs();
    step();
    step();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80FF_0000;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0080 || stall_cycles !== 16'd6) begin
      errors++; $display("FAIL lbu_result got v=%b data=%h stall=%0d want 1/00000080/6", out_valid, out_data, stall_cycles);
    end
    $display("lbu: addr=00000103 rdata=80ff0000 -> out_data=%h stall=%0d", out_data, stall_cycles);
  endtask

  task automatic test_load_half_fast();
    // LH from 0x102 with the ack in the same cycle the request first rises. Total latency is 2.
    drive_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    step();
    idle_inputs();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80FF_1234;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_80FF || in_ready !== 1'b1) begin
      errors++; $display("FAIL lh_fast got v=%b data=%h rdy=%b want 1/ffff80ff/1", out_valid, out_data, in_ready);
    end
    $display("lh: addr=00000102 rdata=80ff1234 -> out_data=%h", out_data);
    // LHU from 0x100 uses the lower halfword, zero-extended.
    drive_op(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
    step();
    idle_inputs();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234_F00D;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_F00D) begin
      errors++; $display("FAIL lhu_fast got v=%b data=%h want 1/0000f00d", out_valid, out_data);
    end
    $display("lhu: addr=00000100 rdata=1234f00d -> out_data=%h", out_data);
  endtask

  task automatic test_store();
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 1'b0);
    step();
    idle_inputs();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h0000_0200 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF) begin
      errors++; $display("FAIL sh_bus got req=%b we=%b addr=%h be=%b wdata=%h want 1/1/00000200/1100/beefbeef", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    dmem_ack = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL sh_done got v=%b rw=%b err=%b want 1/0/0", out_valid, out_reg_write, misalign_err);
    end
    $display("sh: addr=00000202 wdata=aaaabeef -> be=1100 bus_wdata=beefbeef");

    drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 5'd0, 1'b0);
    step();
    idle_inputs();
    checks++;
    if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h7878_7878 || dmem_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL sb_bus got be=%b wdata=%h addr=%h want 0010/78787878/00000200", dmem_be, dmem_wdata, dmem_addr);
    end
    dmem_ack = 1'b1;
    step();
    idle_inputs();
    $display("sb: addr=00000201 wdata=12345678 -> be=0010 bus_wdata=78787878");

    drive_op(1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 1'b0);
    step();
    idle_inputs();
    checks++;
    if (dmem_be !== 4'b1111 || dmem_wdata !== 32'hCAFE_F00D || dmem_we !== 1'b1) begin
      errors++; $display("FAIL sw_bus got be=%b wdata=%h we=%b want 1111/cafef00d/1", dmem_be, dmem_wdata, dmem_we);
    end
    dmem_ack = 1'b1;
    step();
    idle_inputs();
    $display("sw: addr=00000204 wdata=cafef00d -> be=1111");
  endtask

  task automatic test_misalign();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 1'b1);
    step();
    idle_inputs();
    checks++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b1 || misalign_err !== 1'b1 || out_reg_write !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL lw_misalign got req=%b v=%b err=%b rw=%b rdy=%b want 0/1/1/0/1", dmem_req, out_valid, misalign_err, out_reg_write, in_ready);
    end
    $display("lw misaligned: addr=00000101 -> misalign_err=%b", misalign_err);
    step();
    checks++;
    if (misalign_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse got err=%b v=%b want 0/0", misalign_err, out_valid);
    end
    // A store with funct3=100 is illegal even when the address is aligned.
    drive_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd0, 1'b0);
    step();
    idle_inputs();
    checks++;
    if (dmem_req !== 1'b0 || misalign_err !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL st_illegal got req=%b err=%b v=%b want 0/1/1", dmem_req, misalign_err, out_valid);
    end
    $display("store funct3=100: -> misalign_err=%b", misalign_err);
    step();
  endtask

  task automatic test_flush();
    // A flush in IDLE blocks the entry.
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd4, 1'b1);
    flush = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got v=%b want 0", out_valid); end
    $display("flush idle: out_valid=%b", out_valid);

    // A flush during ACCESS drains the transaction and emits no result.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd6, 1'b1);
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (dmem_req !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drain got req=%b rdy=%b v=%b want 1/0/0", dmem_req, in_ready, out_valid);
    end
    step();
    checks++;
    if (dmem_req !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hold got req=%b v=%b want 1/0", dmem_req, out_valid);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done got v=%b req=%b rdy=%b want 0/0/1", out_valid, dmem_req, in_ready);
    end
    $display("flush access: result discarded, in_ready=%b", in_ready);
  endtask

  task automatic test_reset_mid_access();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd10, 1'b1);
    step();
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b0 || stall_cycles !== 16'd0 || in_ready !== 1'b1 || dmem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mid got req=%b v=%b stall=%0d rdy=%b addr=%h want 0/0/0/1/0", dmem_req, out_valid, stall_cycles, in_ready, dmem_addr);
    end
    $display("reset mid-access: dmem_req=%b", dmem_req);
    #2;
    reset = 1'b1;
    step();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd11, 1'b1);
    step();
    idle_inputs();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_CAFE;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0BAD_CAFE || out_rd !== 5'd11) begin
      errors++; $display("FAIL post_reset_lw got v=%b data=%h rd=%0d want 1/0badcafe/11", out_valid, out_data, out_rd);
    end
    $display("lw after reset: addr=00000104 -> out_data=%h", out_data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_byte();
    test_load_half_fast();
    test_store();
    test_misalign();
    test_flush();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
